// File: rtl/cr_kme_fifo_out_stage.sv
// Pops KME RAM FIFO words into a 2-entry skid buffer, tags/drops uncorrectable-ECC words; 1-cycle latency.
// Backpressure: out_ready stalls the head; fifo_out_ack drops only when both entries are full (registered state only).
module cr_kme_fifo_out_stage #(
  parameter int unsigned DATA_W   = 71,
  parameter int unsigned CNT_W    = 16,
  parameter bit          DROP_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_out,
  input  logic              fifo_out_valid,
  input  logic              fifo_mbe,
  output logic              fifo_out_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_err,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   head_dat_q, skid_dat_q;
  logic                head_err_q, skid_err_q;
  logic                out_vld_q;
  logic                err_sticky_q;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic accept, keep, pop, err_evt;

  // Ack depends only on registered state, never on out_ready.
  assign accept  = fifo_out_valid & (state_q != FULL) & ~rst;
  assign keep    = accept & ~(DROP_ERR & fifo_mbe);
  assign pop     = out_vld_q & out_ready;
  assign err_evt = accept & fifo_mbe;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt) begin
      if (clr_err)
        err_cnt_d = CNT_W'(1);
      else if (err_cnt_q != {CNT_W{1'b1}})
        err_cnt_d = err_cnt_q + CNT_W'(1);
    end else if (clr_err) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_dat_q   <= '0;
      head_err_q   <= 1'b0;
      skid_dat_q   <= '0;
      skid_err_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (keep) begin
            head_dat_q <= fifo_out;
            head_err_q <= fifo_mbe;
            out_vld_q  <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (keep && pop) begin
            head_dat_q <= fifo_out;
            head_err_q <= fifo_mbe;
          end else if (keep) begin
            skid_dat_q <= fifo_out;
            skid_err_q <= fifo_mbe;
            state_q    <= FULL;
          end else if (pop) begin
            out_vld_q  <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_dat_q <= skid_dat_q;
            head_err_q <= skid_err_q;
            state_q    <= ONE;
          end
        end
        default: begin
          out_vld_q <= 1'b0;
          state_q   <= EMPTY;
        end
      endcase

      if (err_evt)
        err_sticky_q <= 1'b1;
      else if (clr_err)
        err_sticky_q <= 1'b0;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign fifo_out_ack = accept;
  assign out_data     = head_dat_q;
  assign out_valid    = out_vld_q;
  assign out_err      = head_err_q;
  assign err_sticky   = err_sticky_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_cr_kme_fifo_out_stage.sv
// Directed bench: forward-mode, drop-mode and 2-bit-counter instances share one stimulus bus.
module tb_cr_kme_fifo_out_stage;

  localparam int DW = 71;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] fifo_out = '0;
  logic          fifo_out_valid = 1'b0;
  logic          fifo_mbe = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_err = 1'b0;

  logic          ack0, vld0, err0, stk0;
  logic [DW-1:0] dat0;
  logic [15:0]   cnt0;
  logic          ack1, vld1, err1, stk1;
  logic [DW-1:0] dat1;
  logic [15:0]   cnt1;
  logic          ack2, vld2, err2, stk2;
  logic [DW-1:0] dat2;
  logic [1:0]    cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cr_kme_fifo_out_stage #(.DATA_W(DW), .CNT_W(16), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_mbe(fifo_mbe), .fifo_out_ack(ack0), .out_data(dat0), .out_valid(vld0),
    .out_err(err0), .out_ready(out_ready), .clr_err(clr_err), .err_sticky(stk0),
    .err_cnt(cnt0));

  cr_kme_fifo_out_stage #(.DATA_W(DW), .CNT_W(16), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_mbe(fifo_mbe), .fifo_out_ack(ack1), .out_data(dat1), .out_valid(vld1),
    .out_err(err1), .out_ready(out_ready), .clr_err(clr_err), .err_sticky(stk1),
    .err_cnt(cnt1));

  cr_kme_fifo_out_stage #(.DATA_W(DW), .CNT_W(2), .DROP_ERR(1'b0)) dut2 (
    .clk(clk), .rst(rst), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_mbe(fifo_mbe), .fifo_out_ack(ack2), .out_data(dat2), .out_valid(vld2),
    .out_err(err2), .out_ready(out_ready), .clr_err(clr_err), .err_sticky(stk2),
    .err_cnt(cnt2));

  // Inputs change 1ns after the rising edge; checks run 2ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic v, input logic m);
    fifo_out       = d;
    fifo_out_valid = v;
    fifo_mbe       = m;
  endtask

  task automatic do_reset();
    offer('0, 1'b0, 1'b0);
    out_ready = 1'b0;
    clr_err   = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if ({vld0, err0, stk0, cnt0, dat0} !== {3'b000, 16'd0, {DW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state: vld=%b err=%b stk=%b cnt=%0d dat=%0h required all zero", vld0, err0, stk0, cnt0, dat0);
    end
    offer(DW'(1), 1'b1, 1'b1);
    tick();
    offer(DW'(2), 1'b1, 1'b0);
    tick();
    offer(DW'(3), 1'b1, 1'b0);
    settle();
    checks++;
    if ({ack0, vld0, cnt0} !== {1'b0, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL reset_full_before: ack=%b vld=%b cnt=%0d required ack=0 vld=1 cnt=1", ack0, vld0, cnt0);
    end
    rst = 1'b1;
    settle();
    checks++;
    if ({ack0, vld0, cnt0, stk0} !== {1'b0, 1'b0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async: ack=%b vld=%b cnt=%0d stk=%b required 0 0 0 0", ack0, vld0, cnt0, stk0);
    end
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    offer(DW'(8'h33), 1'b1, 1'b0);
    settle();
    checks++;
    if (ack0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ack: ack=%b required 1", ack0);
    end
    tick();
    offer('0, 1'b0, 1'b0);
    settle();
    checks++;
    if ({vld0, dat0} !== {1'b1, DW'(8'h33)}) begin
      failures++;
      $display("FAIL reset_first_word: vld=%b dat=%0h required vld=1 dat=33", vld0, dat0);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(DW'(i), 1'b1, 1'b0);
      settle();
      checks++;
      if (ack0 !== 1'b1) begin
        failures++;
        $display("FAIL stream_ack[%0d]: ack=%b required 1", i, ack0);
      end
      if (i > 0) begin
        checks++;
        if ({vld0, dat0} !== {1'b1, DW'(i - 1)}) begin
          failures++;
          $display("FAIL stream_data[%0d]: vld=%b dat=%0h required vld=1 dat=%0h", i, vld0, dat0, i - 1);
        end
      end
      tick();
    end
    offer('0, 1'b0, 1'b0);
    settle();
    checks++;
    if ({vld0, dat0} !== {1'b1, DW'(7)}) begin
      failures++;
      $display("FAIL stream_last: vld=%b dat=%0h required vld=1 dat=7", vld0, dat0);
    end
    tick();
    settle();
    checks++;
    if (vld0 !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty: vld=%b required 0", vld0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    offer(DW'(8'hA1), 1'b1, 1'b0);
    tick();
    offer(DW'(8'hA2), 1'b1, 1'b0);
    tick();
    offer(DW'(8'hA3), 1'b1, 1'b0);
    settle();
    checks++;
    if ({ack0, vld0, dat0} !== {1'b0, 1'b1, DW'(8'hA1)}) begin
      failures++;
      $display("FAIL bp_full: ack=%b vld=%b dat=%0h required ack=0 vld=1 dat=a1", ack0, vld0, dat0);
    end
    tick();
    settle();
    checks++;
    if ({ack0, dat0} !== {1'b0, DW'(8'hA1)}) begin
      failures++;
      $display("FAIL bp_hold: ack=%b dat=%0h required ack=0 dat=a1", ack0, dat0);
    end
    out_ready = 1'b1;
    settle();
    checks++;
    if (ack0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_comb_ack: ack=%b required 0", ack0);
    end
    tick();
    settle();
    checks++;
    if ({ack0, vld0, dat0} !== {1'b1, 1'b1, DW'(8'hA2)}) begin
      failures++;
      $display("FAIL bp_drain2: ack=%b vld=%b dat=%0h required ack=1 vld=1 dat=a2", ack0, vld0, dat0);
    end
    tick();
    offer('0, 1'b0, 1'b0);
    settle();
    checks++;
    if ({vld0, dat0} !== {1'b1, DW'(8'hA3)}) begin
      failures++;
      $display("FAIL bp_drain3: vld=%b dat=%0h required vld=1 dat=a3", vld0, dat0);
    end
    tick();
    settle();
    checks++;
    if (vld0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: vld=%b required 0", vld0);
    end
  endtask

  task automatic test_ecc_forward();
    logic [DW-1:0] words [3];
    logic          mbes  [3];
    words = '{DW'(8'h10), DW'(8'h5A), DW'(8'h11)};
    mbes  = '{1'b0, 1'b1, 1'b0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(words[i], 1'b1, mbes[i]);
      tick();
      offer('0, 1'b0, 1'b0);
      settle();
      checks++;
      if ({vld0, dat0, err0} !== {1'b1, words[i], mbes[i]}) begin
        failures++;
        $display("FAIL fwd_word[%0d]: vld=%b dat=%0h err=%b required vld=1 dat=%0h err=%b", i, vld0, dat0, err0, words[i], mbes[i]);
      end
    end
    checks++;
    if ({stk0, cnt0} !== {1'b1, 16'd1}) begin
      failures++;
      $display("FAIL fwd_errs: stk=%b cnt=%0d required stk=1 cnt=1", stk0, cnt0);
    end
  endtask

  task automatic test_ecc_drop();
    do_reset();
    out_ready = 1'b1;
    offer(DW'(8'h0A), 1'b1, 1'b0);
    tick();
    offer(DW'(8'h0B), 1'b1, 1'b1);
    settle();
    checks++;
    if ({ack1, vld1, dat1} !== {1'b1, 1'b1, DW'(8'h0A)}) begin
      failures++;
      $display("FAIL drop_a: ack=%b vld=%b dat=%0h required ack=1 vld=1 dat=a", ack1, vld1, dat1);
    end
    tick();
    offer(DW'(8'h0C), 1'b1, 1'b0);
    settle();
    checks++;
    if (vld1 !== 1'b0) begin
      failures++;
      $display("FAIL drop_b_hidden: vld=%b required 0", vld1);
    end
    tick();
    offer('0, 1'b0, 1'b0);
    settle();
    checks++;
    if ({vld1, dat1, err1, cnt1, stk1} !== {1'b1, DW'(8'h0C), 1'b0, 16'd1, 1'b1}) begin
      failures++;
      $display("FAIL drop_c: vld=%b dat=%0h err=%b cnt=%0d stk=%b required 1 c 0 1 1", vld1, dat1, err1, cnt1, stk1);
    end
  endtask

  task automatic test_counter();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      offer(DW'(i), 1'b1, 1'b1);
      tick();
      offer('0, 1'b0, 1'b0);
      settle();
      checks++;
      if (cnt2 !== 2'((i > 3) ? 3 : i)) begin
        failures++;
        $display("FAIL cnt_sat[%0d]: cnt=%0d required %0d", i, cnt2, (i > 3) ? 3 : i);
      end
    end
    offer('0, 1'b0, 1'b1);
    tick();
    settle();
    checks++;
    if (cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL cnt_mbe_novalid: cnt=%0d required 3", cnt2);
    end
    clr_err = 1'b1;
    offer(DW'(9), 1'b1, 1'b1);
    tick();
    clr_err = 1'b0;
    offer('0, 1'b0, 1'b0);
    settle();
    checks++;
    if ({stk2, cnt2} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL cnt_clr_evt: stk=%b cnt=%0d required stk=1 cnt=1", stk2, cnt2);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    settle();
    checks++;
    if ({stk2, cnt2} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL cnt_clr: stk=%b cnt=%0d required stk=0 cnt=0", stk2, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_ecc_forward();
    test_ecc_drop();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
